// File: rtl/spartan_pkg.sv
// Shared Spartan bus definitions: beat codes, ID field position and FSM state encodings.
// Request and response codes share the two MSBs of the bus.
package spartan_pkg;

  localparam int ID_LSB = 41;

  localparam logic [1:0] SP_RD_HDR  = 2'b00;
  localparam logic [1:0] SP_WR_HDR  = 2'b01;
  localparam logic [1:0] SP_WR_DAT  = 2'b10;
  localparam logic [1:0] SP_WR_LAST = 2'b11;

  localparam logic [1:0] SP_B_RSP  = 2'b00;
  localparam logic [1:0] SP_R_HDR  = 2'b01;
  localparam logic [1:0] SP_R_DAT  = 2'b10;
  localparam logic [1:0] SP_R_LAST = 2'b11;

  typedef logic [1:0] req_state_t;
  typedef logic [1:0] rsp_state_t;

  localparam req_state_t Q_IDLE  = 2'd0;
  localparam req_state_t Q_LOCK0 = 2'd1;
  localparam req_state_t Q_LOCK1 = 2'd2;

  localparam rsp_state_t R_IDLE   = 2'd0;
  localparam rsp_state_t R_BURST0 = 2'd1;
  localparam rsp_state_t R_BURST1 = 2'd2;

  // Header beats (request 00/01, response 00/01) are the only ones carrying a routable ID.
  function automatic logic is_hdr(input logic [1:0] code);
    return (code == SP_RD_HDR) || (code == SP_WR_HDR);
  endfunction

endpackage

// File: rtl/spartan_rsp_route.sv
// Response demux: routes downstream responses to the issuing master by the ID index bit
// and keeps multi-beat read bursts pinned to that master until the last beat.
module spartan_rsp_route
  import spartan_pkg::*;
#(
  parameter int ID_WIDTH = 5,
  parameter int BWIDTH   = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [BWIDTH+1:0] SpSBUS,
  input  logic              SpSVLD,
  output logic              SpSRDY,
  output logic [BWIDTH+1:0] Sp0SBUS,
  output logic              Sp0SVLD,
  input  logic              Sp0SRDY,
  output logic [BWIDTH+1:0] Sp1SBUS,
  output logic              Sp1SVLD,
  input  logic              Sp1SRDY
);

  localparam int IDX_BIT = ID_LSB + ID_WIDTH;

  rsp_state_t        state_r;
  rsp_state_t        state_nxt_s;
  logic [1:0]        code_s;
  logic              idx_s;
  logic [BWIDTH+1:0] bus_s;
  logic              vld0_s;
  logic              vld1_s;
  logic              srdy_s;
  logic              hs_s;

  assign code_s = SpSBUS[BWIDTH+1:BWIDTH];
  assign idx_s  = SpSBUS[IDX_BIT];
  assign hs_s   = SpSVLD & srdy_s;

  // Demux: headers in idle pick the master and lose the index bit; stray data beats are drained.
  always_comb begin
    bus_s  = SpSBUS;
    vld0_s = 1'b0;
    vld1_s = 1'b0;
    srdy_s = 1'b0;
    case (state_r)
      R_IDLE: begin
        if (is_hdr(code_s)) begin
          bus_s[IDX_BIT] = 1'b0;
          if (idx_s) begin
            vld1_s = SpSVLD;
            srdy_s = SpSVLD & Sp1SRDY;
          end else begin
            vld0_s = SpSVLD;
            srdy_s = SpSVLD & Sp0SRDY;
          end
        end else begin
          srdy_s = SpSVLD;
        end
      end
      R_BURST0: begin
        vld0_s = SpSVLD;
        srdy_s = Sp0SRDY;
      end
      R_BURST1: begin
        vld1_s = SpSVLD;
        srdy_s = Sp1SRDY;
      end
      default: begin
        srdy_s = 1'b0;
      end
    endcase
  end

  // Next burst state, advanced only on a completed response handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      R_IDLE: begin
        if (hs_s && (code_s == SP_R_HDR)) begin
          state_nxt_s = idx_s ? R_BURST1 : R_BURST0;
        end else begin
          state_nxt_s = R_IDLE;
        end
      end
      R_BURST0, R_BURST1: begin
        if (hs_s && (code_s == SP_R_LAST)) begin
          state_nxt_s = R_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = R_IDLE;
      end
    endcase
  end

  // Response state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= R_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  assign Sp0SBUS = bus_s;
  assign Sp1SBUS = bus_s;
  assign Sp0SVLD = vld0_s;
  assign Sp1SVLD = vld1_s;
  assign SpSRDY  = srdy_s;

endmodule

// File: rtl/spartan_arb2.sv
// Two-master Spartan arbiter: round-robin packet grant with ID tagging on requests,
// index-steered response routing; both paths are combinational passthroughs.
module spartan_arb2
  import spartan_pkg::*;
#(
  parameter int ID_WIDTH = 5,
  parameter int BWIDTH   = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [BWIDTH+1:0] Sp0MBUS,
  input  logic              Sp0MVLD,
  output logic              Sp0MRDY,
  output logic [BWIDTH+1:0] Sp0SBUS,
  output logic              Sp0SVLD,
  input  logic              Sp0SRDY,
  input  logic [BWIDTH+1:0] Sp1MBUS,
  input  logic              Sp1MVLD,
  output logic              Sp1MRDY,
  output logic [BWIDTH+1:0] Sp1SBUS,
  output logic              Sp1SVLD,
  input  logic              Sp1SRDY,
  output logic [BWIDTH+1:0] SpMBUS,
  output logic              SpMVLD,
  input  logic              SpMRDY,
  input  logic [BWIDTH+1:0] SpSBUS,
  input  logic              SpSVLD,
  output logic              SpSRDY
);

  localparam int IDX_BIT = ID_LSB + ID_WIDTH;

  req_state_t        q_state_r;
  req_state_t        q_state_nxt_s;
  logic              ptr_r;
  logic              ptr_nxt_s;
  logic              sel_s;
  logic              gnt_vld_s;
  logic              locked_s;
  logic [BWIDTH+1:0] req_bus_s;
  logic [1:0]        req_code_s;
  logic              mvld_s;
  logic              tag_s;
  logic              req_hs_s;

  // Grant selection: locked master wins outright, otherwise round-robin between valid masters.
  always_comb begin
    sel_s     = 1'b0;
    gnt_vld_s = 1'b0;
    locked_s  = 1'b0;
    case (q_state_r)
      Q_IDLE: begin
        gnt_vld_s = Sp0MVLD | Sp1MVLD;
        if (Sp0MVLD && Sp1MVLD) begin
          sel_s = ptr_r;
        end else begin
          sel_s = Sp1MVLD;
        end
      end
      Q_LOCK0: begin
        locked_s  = 1'b1;
        gnt_vld_s = 1'b1;
        sel_s     = 1'b0;
      end
      Q_LOCK1: begin
        locked_s  = 1'b1;
        gnt_vld_s = 1'b1;
        sel_s     = 1'b1;
      end
      default: begin
        gnt_vld_s = 1'b0;
      end
    endcase
  end

  assign req_bus_s  = sel_s ? Sp1MBUS : Sp0MBUS;
  assign mvld_s     = sel_s ? Sp1MVLD : Sp0MVLD;
  assign req_code_s = req_bus_s[BWIDTH+1:BWIDTH];
  // Only an arbitrated header gets its index bit overwritten; locked beats pass untouched.
  assign tag_s      = ~locked_s & is_hdr(req_code_s);
  assign req_hs_s   = gnt_vld_s & mvld_s & SpMRDY;

  assign SpMBUS  = {req_bus_s[BWIDTH+1:IDX_BIT+1],
                    (tag_s ? sel_s : req_bus_s[IDX_BIT]),
                    req_bus_s[IDX_BIT-1:0]};
  assign SpMVLD  = mvld_s;
  assign Sp0MRDY = gnt_vld_s & ~sel_s & SpMRDY;
  assign Sp1MRDY = gnt_vld_s & sel_s & SpMRDY;

  // Packet-level arbitration state: reads rotate the pointer, writes lock until the last beat.
  always_comb begin
    q_state_nxt_s = q_state_r;
    ptr_nxt_s     = ptr_r;
    case (q_state_r)
      Q_IDLE: begin
        if (req_hs_s && (req_code_s == SP_RD_HDR)) begin
          ptr_nxt_s = ~sel_s;
        end else if (req_hs_s && (req_code_s == SP_WR_HDR)) begin
          q_state_nxt_s = sel_s ? Q_LOCK1 : Q_LOCK0;
        end else begin
          q_state_nxt_s = Q_IDLE;
        end
      end
      Q_LOCK0, Q_LOCK1: begin
        if (req_hs_s && (req_code_s == SP_WR_LAST)) begin
          q_state_nxt_s = Q_IDLE;
          ptr_nxt_s     = ~sel_s;
        end else begin
          q_state_nxt_s = q_state_r;
        end
      end
      default: begin
        q_state_nxt_s = Q_IDLE;
      end
    endcase
  end

  // Request state and priority pointer registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_state_r <= Q_IDLE;
      ptr_r     <= 1'b0;
    end else begin
      q_state_r <= q_state_nxt_s;
      ptr_r     <= ptr_nxt_s;
    end
  end

  spartan_rsp_route #(
    .ID_WIDTH (ID_WIDTH),
    .BWIDTH   (BWIDTH)
  ) u_rsp_route (
    .CLK     (CLK),
    .RST     (RST),
    .SpSBUS  (SpSBUS),
    .SpSVLD  (SpSVLD),
    .SpSRDY  (SpSRDY),
    .Sp0SBUS (Sp0SBUS),
    .Sp0SVLD (Sp0SVLD),
    .Sp0SRDY (Sp0SRDY),
    .Sp1SBUS (Sp1SBUS),
    .Sp1SVLD (Sp1SVLD),
    .Sp1SRDY (Sp1SRDY)
  );

endmodule

// File: tb/tb_spartan_arb2.sv
// Scoreboard bench for spartan_arb2: the driver predicts each cycle's outputs from a
// packet-level model and queues them; a monitor process pops and compares.
module tb_spartan_arb2;
  import spartan_pkg::*;

  localparam int IW  = 5;
  localparam int BW  = 64;
  localparam int W   = BW + 2;
  localparam int IDX = ID_LSB + IW;

  logic CLK = 1'b0;
  logic RST;
  logic [W-1:0] Sp0MBUS, Sp1MBUS, SpMBUS, Sp0SBUS, Sp1SBUS, SpSBUS;
  logic Sp0MVLD, Sp0MRDY, Sp0SVLD, Sp0SRDY;
  logic Sp1MVLD, Sp1MRDY, Sp1SVLD, Sp1SRDY;
  logic SpMVLD, SpMRDY, SpSVLD, SpSRDY;

  always #5 CLK = ~CLK;

  spartan_arb2 #(.ID_WIDTH(IW), .BWIDTH(BW)) dut (
    .CLK(CLK), .RST(RST),
    .Sp0MBUS(Sp0MBUS), .Sp0MVLD(Sp0MVLD), .Sp0MRDY(Sp0MRDY),
    .Sp0SBUS(Sp0SBUS), .Sp0SVLD(Sp0SVLD), .Sp0SRDY(Sp0SRDY),
    .Sp1MBUS(Sp1MBUS), .Sp1MVLD(Sp1MVLD), .Sp1MRDY(Sp1MRDY),
    .Sp1SBUS(Sp1SBUS), .Sp1SVLD(Sp1SVLD), .Sp1SRDY(Sp1SRDY),
    .SpMBUS(SpMBUS), .SpMVLD(SpMVLD), .SpMRDY(SpMRDY),
    .SpSBUS(SpSBUS), .SpSVLD(SpSVLD), .SpSRDY(SpSRDY)
  );

  typedef struct {
    logic         mvld;
    logic [W-1:0] mbus;
    logic         mrdy0;
    logic         mrdy1;
    logic         svld0;
    logic         svld1;
    logic         srdy;
    logic [W-1:0] sbus;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  bit   active = 1'b0;

  // Reference model state: owner of a write packet (-1 none), favoured master, burst destination.
  int owner  = -1;
  int favour = 0;
  int rdest  = -1;

  logic [W-1:0] z = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [W-1:0] mk(input logic [1:0] code, input logic [IW-1:0] id);
    logic [W-1:0] x;
    x[31:0]  = $urandom;
    x[63:32] = $urandom;
    x[W-1:W-2] = code;
    x[ID_LSB+IW-1:ID_LSB] = id;
    x[IDX] = 1'($urandom);
    return x;
  endfunction

  function automatic logic [W-1:0] mkr(input logic [1:0] code, input logic [IW:0] id);
    logic [W-1:0] x;
    x[31:0]  = $urandom;
    x[63:32] = $urandom;
    x[W-1:W-2] = code;
    x[IDX:ID_LSB] = id;
    return x;
  endfunction

  task automatic step(input bit rst, input bit v0, input logic [W-1:0] b0,
                      input bit v1, input logic [W-1:0] b1, input bit mrdy,
                      input bit svld, input logic [W-1:0] sb, input bit r0, input bit r1);
    exp_t e;
    int g, d;
    bit v[2];
    bit rr[2];
    logic [W-1:0] b[2];
    logic [1:0] c, c2;
    @(negedge CLK);
    RST = rst; Sp0MVLD = v0; Sp0MBUS = b0; Sp1MVLD = v1; Sp1MBUS = b1;
    SpMRDY = mrdy; SpSVLD = svld; SpSBUS = sb; Sp0SRDY = r0; Sp1SRDY = r1;
    v[0] = v0; v[1] = v1; b[0] = b0; b[1] = b1; rr[0] = r0; rr[1] = r1;
    if (owner >= 0) g = owner;
    else if (v0 && v1) g = favour;
    else if (v1) g = 1;
    else if (v0) g = 0;
    else g = -1;
    e.mvld  = (g >= 0) ? v[g] : 1'b0;
    e.mbus  = (g >= 0) ? b[g] : z;
    if (g >= 0 && owner < 0 && b[g][W-1] == 1'b0) e.mbus[IDX] = (g == 1);
    e.mrdy0 = (g == 0) && mrdy;
    e.mrdy1 = (g == 1) && mrdy;
    c = sb[W-1:W-2];
    e.svld0 = 1'b0; e.svld1 = 1'b0; e.srdy = 1'b0; e.sbus = sb; d = -1;
    if (rdest >= 0) begin
      d = rdest;
      e.srdy = rr[d];
      if (d == 0) e.svld0 = svld; else e.svld1 = svld;
    end else if (svld && c[1] == 1'b0) begin
      d = int'(sb[IDX]);
      e.sbus[IDX] = 1'b0;
      e.srdy = rr[d];
      if (d == 0) e.svld0 = 1'b1; else e.svld1 = 1'b1;
    end else if (svld) begin
      e.srdy = 1'b1;
    end
    exp_q.push_back(e);
    active = 1'b1;
    if (rst) begin
      owner = -1; favour = 0; rdest = -1;
    end else begin
      if (g >= 0 && v[g] && mrdy) begin
        c2 = b[g][W-1:W-2];
        if (owner < 0) begin
          if (c2 == SP_RD_HDR) favour = 1 - g;
          else if (c2 == SP_WR_HDR) owner = g;
        end else if (c2 == SP_WR_LAST) begin
          owner = -1; favour = 1 - g;
        end
      end
      if (svld && e.srdy) begin
        if (rdest < 0 && c == SP_R_HDR) rdest = d;
        else if (rdest >= 0 && c == SP_R_LAST) rdest = -1;
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, z, 1'b0, z, 1'b0, 1'b0, z, 1'b0, 1'b0);
  endtask

  // Monitor: one expectation per driven cycle, compared well after the inputs settle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (exp_q.size() == 0) begin
        if (active) begin
          n_total++;
          $display("FAIL scoreboard: got empty queue expected an entry");
        end
      end else begin
        e = exp_q.pop_front();
        check("SpMVLD", W'(SpMVLD), W'(e.mvld));
        if (e.mvld) check("SpMBUS", SpMBUS, e.mbus);
        check("Sp0MRDY", W'(Sp0MRDY), W'(e.mrdy0));
        check("Sp1MRDY", W'(Sp1MRDY), W'(e.mrdy1));
        check("Sp0SVLD", W'(Sp0SVLD), W'(e.svld0));
        check("Sp1SVLD", W'(Sp1SVLD), W'(e.svld1));
        check("SpSRDY", W'(SpSRDY), W'(e.srdy));
        if (e.svld0) check("Sp0SBUS", Sp0SBUS, e.sbus);
        if (e.svld1) check("Sp1SBUS", Sp1SBUS, e.sbus);
      end
    end
  end

  initial begin
    logic [W-1:0] rsp[5];
    logic [W-1:0] rd0;
    int k;
    bit tog;
    RST = 1'b1; Sp0MVLD = 1'b0; Sp1MVLD = 1'b0; SpMRDY = 1'b0; SpSVLD = 1'b0;
    Sp0MBUS = z; Sp1MBUS = z; SpSBUS = z; Sp0SRDY = 1'b0; Sp1SRDY = 1'b0;
    repeat (2) @(posedge CLK);
    idle();
    // Read from master 0, then a write response tagged for master 1.
    step(1'b0, 1'b1, mk(SP_RD_HDR, 5'h03), 1'b0, z, 1'b1, 1'b0, z, 1'b0, 1'b0);
    step(1'b0, 1'b0, z, 1'b0, z, 1'b0, 1'b1, mkr(SP_B_RSP, 6'h23), 1'b0, 1'b1);
    // Simultaneous read headers after reset alternate strictly.
    step(1'b1, 1'b0, z, 1'b0, z, 1'b0, 1'b0, z, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b1, mk(SP_RD_HDR, 5'(i)), 1'b1, mk(SP_RD_HDR, 5'(i + 8)), 1'b1, 1'b0, z, 1'b0, 1'b0);
    // Master 1 write packet locks out a waiting master 0 read.
    rd0 = mk(SP_RD_HDR, 5'h11);
    step(1'b0, 1'b0, z, 1'b1, mk(SP_WR_HDR, 5'h07), 1'b1, 1'b0, z, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, rd0, 1'b1, mk(SP_WR_DAT, 5'h07), 1'b1, 1'b0, z, 1'b0, 1'b0);
    step(1'b0, 1'b1, rd0, 1'b1, mk(SP_WR_LAST, 5'h07), 1'b1, 1'b0, z, 1'b0, 1'b0);
    step(1'b0, 1'b1, rd0, 1'b0, z, 1'b1, 1'b0, z, 1'b0, 1'b0);
    // Read response burst to master 1 with a toggling ready.
    rsp[0] = mkr(SP_R_HDR, 6'h25);
    for (int i = 1; i < 4; i++) rsp[i] = mkr(SP_R_DAT, 6'h05);
    rsp[4] = mkr(SP_R_LAST, 6'h05);
    k = 0; tog = 1'b1;
    while (k < 5) begin
      step(1'b0, 1'b0, z, 1'b0, z, 1'b0, 1'b1, rsp[k], 1'b1, tog);
      if (tog) k++;
      tog = ~tog;
    end
    // Stray data beat in response idle is drained.
    step(1'b0, 1'b0, z, 1'b0, z, 1'b0, 1'b1, mkr(SP_R_DAT, 6'h21), 1'b1, 1'b1);
    // Reset in the middle of a master 0 write lock.
    step(1'b0, 1'b1, mk(SP_WR_HDR, 5'h02), 1'b0, z, 1'b1, 1'b0, z, 1'b0, 1'b0);
    step(1'b0, 1'b1, mk(SP_WR_DAT, 5'h02), 1'b0, z, 1'b1, 1'b0, z, 1'b0, 1'b0);
    step(1'b1, 1'b1, mk(SP_WR_DAT, 5'h02), 1'b0, z, 1'b1, 1'b0, z, 1'b0, 1'b0);
    step(1'b0, 1'b0, z, 1'b1, mk(SP_RD_HDR, 5'h09), 1'b1, 1'b0, z, 1'b0, 1'b0);
    idle();
    // Randomised traffic on both paths simultaneously.
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 9) < 6, mk(2'($urandom), 5'($urandom)),
           $urandom_range(0, 9) < 6, mk(2'($urandom), 5'($urandom)),
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 6, mkr(2'($urandom), 6'($urandom)),
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
    @(negedge CLK);
    active = 1'b0;
    repeat (2) @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
